// File: rtl/counter_bank_pkg.sv
// Shared constants for the counter_bank slice: count direction encodings and
// bound-handling modes used by the SATURATE parameter.
package counter_bank_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage : counter_bank_pkg

// File: rtl/counter_bank_ch.sv
// One counter channel: load/step/hold on the rising edge, terminal-count pulse
// and sticky overflow. COUNTER_BANK_NEGEDGE_EN adds a falling-edge copy on cnt_n.
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             dir,
  input  logic             wen,
  input  logic [WIDTH-1:0] dat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic [WIDTH-1:0] cnt_n
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               SAT_EN   = (SATURATE == MODE_SAT);

  // A step crosses a bound when it would leave [0, 2^WIDTH-1]; loads never do.
  function automatic logic bound_hit(
    input logic [WIDTH-1:0] cur,
    input logic             wen_i,
    input logic             cen_i,
    input logic             dir_i
  );
    logic hit;
    hit = 1'b0;
    if (!wen_i && cen_i) begin
      if (dir_i == DIR_UP) begin
        hit = (cur == CNT_MAX);
      end else begin
        hit = (cur == CNT_ZERO);
      end
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  function automatic logic [WIDTH-1:0] next_value(
    input logic [WIDTH-1:0] cur,
    input logic             wen_i,
    input logic             cen_i,
    input logic             dir_i,
    input logic [WIDTH-1:0] dat_i
  );
    logic [WIDTH-1:0] val;
    val = cur;
    if (wen_i) begin
      val = dat_i;
    end else if (cen_i) begin
      if (dir_i == DIR_UP) begin
        if (cur == CNT_MAX) begin
          val = SAT_EN ? cur : CNT_ZERO;
        end else begin
          val = cur + CNT_ONE;
        end
      end else begin
        if (cur == CNT_ZERO) begin
          val = SAT_EN ? cur : CNT_MAX;
        end else begin
          val = cur - CNT_ONE;
        end
      end
    end else begin
      val = cur;
    end
    return val;
  endfunction

  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             tc_d, tc_q;
  logic             ovf_d, ovf_q;

  // Next-state for the rising-edge counter; a coincident set beats clr_ovf.
  always_comb begin
    cnt_d = next_value(cnt_q, wen, cen, dir, dat);
    tc_d  = bound_hit(cnt_q, wen, cen, dir);
    ovf_d = ovf_q;
    if (tc_d) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Rising-edge state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

`ifdef COUNTER_BANK_NEGEDGE_EN
  logic [WIDTH-1:0] cnt_n_d, cnt_n_q;

  // Falling-edge copy follows its own state with the same load/step rules.
  always_comb begin
    cnt_n_d = next_value(cnt_n_q, wen, cen, dir, dat);
  end

  // Falling-edge state register with asynchronous clear.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_n_q <= CNT_ZERO;
    end else begin
      cnt_n_q <= cnt_n_d;
    end
  end

  assign cnt_n = cnt_n_q;
`else
  assign cnt_n = CNT_ZERO;
`endif

endmodule : counter_bank_ch

// File: rtl/counter_bank.sv
// Bank of CHANNELS independent up/down counters sharing one clock and reset.
// Optional falling-edge copies on cnt_n are enabled by COUNTER_BANK_NEGEDGE_EN.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       cen,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       wen,
  input  logic [CHANNELS*WIDTH-1:0] dat,
  input  logic [CHANNELS-1:0]       clr_ovf,
  output logic [CHANNELS*WIDTH-1:0] cnt,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS*WIDTH-1:0] cnt_n
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    counter_bank_ch #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen     (cen[g]),
      .dir     (dir[g]),
      .wen     (wen[g]),
      .dat     (dat[g*WIDTH +: WIDTH]),
      .clr_ovf (clr_ovf[g]),
      .cnt     (cnt[g*WIDTH +: WIDTH]),
      .tc      (tc[g]),
      .ovf     (ovf[g]),
      .cnt_n   (cnt_n[g*WIDTH +: WIDTH])
    );
  end

endmodule : counter_bank

// File: tb/tb_counter_bank.sv
// Self-checking bench: a wrapping and a saturating instance share stimulus;
// expected values come from an integer model pushed to a scoreboard queue.
module tb_counter_bank;

  localparam int W  = 8;
  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     cen, dir, wen, clr_ovf;
  logic [CH*W-1:0]   dat;
  logic [CH*W-1:0]   cnt_w, cnt_s, cnt_n_w, cnt_n_s;
  logic [CH-1:0]     tc_w, tc_s, ovf_w, ovf_s;

  always #5 clk = ~clk;

  counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dir(dir), .wen(wen), .dat(dat),
    .clr_ovf(clr_ovf), .cnt(cnt_w), .tc(tc_w), .ovf(ovf_w), .cnt_n(cnt_n_w)
  );

  counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dir(dir), .wen(wen), .dat(dat),
    .clr_ovf(clr_ovf), .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s), .cnt_n(cnt_n_s)
  );

  int checks = 0;
  int errors = 0;

  // model index 0 = wrapping instance, 1 = saturating instance
  logic [W-1:0] m_cnt [2][CH];
  logic         m_ovf [2][CH];

  typedef struct packed {
    logic [1:0][CH*W-1:0] cnt;
    logic [1:0][CH*W-1:0] cnt_n;
    logic [1:0][CH-1:0]   tc;
    logic [1:0][CH-1:0]   ovf;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [CH*W-1:0] packed_model(input int m);
    logic [CH*W-1:0] r;
    for (int i = 0; i < CH; i++) r[i*W +: W] = m_cnt[m][i];
    return r;
  endfunction

  function automatic logic [CH*W-1:0] expect_cnt_n(input int m);
`ifdef COUNTER_BANK_NEGEDGE_EN
    return packed_model(m);
`else
    return {(CH*W){1'b0}} | {31'd0, m[0]} & {(CH*W){1'b0}};
`endif
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < CH; i++) begin
        m_cnt[m][i] = '0;
        m_ovf[m][i] = 1'b0;
      end
  endtask

  task automatic idle_inputs();
    cen = '0; dir = '0; wen = '0; clr_ovf = '0; dat = '0;
  endtask

  // One rising edge with current inputs; compare at the following falling edge.
  task automatic step(input string name, input bit mid_check);
    exp_t e;
    logic [1:0][CH*W-1:0] act_cnt, act_n;
    logic [1:0][CH-1:0]   act_tc, act_ovf;
`ifdef COUNTER_BANK_NEGEDGE_EN
    logic [CH*W-1:0] prev_n;
    prev_n = expect_cnt_n(0);
`endif
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < CH; i++) begin
        int   nxt;
        logic hit;
        hit = 1'b0;
        if (wen[i]) begin
          m_cnt[m][i] = dat[i*W +: W];
        end else if (cen[i]) begin
          nxt = int'(m_cnt[m][i]) + (dir[i] ? 1 : -1);
          if (nxt > (1 << W) - 1 || nxt < 0) begin
            hit = 1'b1;
            if (m == 1) nxt = int'(m_cnt[m][i]);
            else        nxt = (nxt + (1 << W)) % (1 << W);
          end
          m_cnt[m][i] = W'(nxt);
        end
        e.tc[m][i] = hit;
        if (hit) m_ovf[m][i] = 1'b1;
        else if (clr_ovf[i]) m_ovf[m][i] = 1'b0;
        e.ovf[m][i] = m_ovf[m][i];
      end
      e.cnt[m]   = packed_model(m);
      e.cnt_n[m] = expect_cnt_n(m);
    end
    sb_q.push_back(e);

    @(posedge clk); #1;
    if (mid_check) begin
`ifdef COUNTER_BANK_NEGEDGE_EN
      checks++;
      if (cnt_n_w !== prev_n) begin
        errors++;
        $display("FAIL %s half-cycle cnt_n got %h exp %h", name, cnt_n_w, prev_n);
      end
`else
      checks++;
      if (cnt_n_w !== {(CH*W){1'b0}}) begin
        errors++;
        $display("FAIL %s half-cycle cnt_n got %h exp 0", name, cnt_n_w);
      end
`endif
      checks++;
      if (cnt_w !== e.cnt[0]) begin
        errors++;
        $display("FAIL %s half-cycle cnt got %h exp %h", name, cnt_w, e.cnt[0]);
      end
    end

    @(negedge clk); #1;
    e = sb_q.pop_front();
    act_cnt[0] = cnt_w;   act_cnt[1] = cnt_s;
    act_n[0]   = cnt_n_w; act_n[1]   = cnt_n_s;
    act_tc[0]  = tc_w;    act_tc[1]  = tc_s;
    act_ovf[0] = ovf_w;   act_ovf[1] = ovf_s;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (act_cnt[m] !== e.cnt[m]) begin
        errors++;
        $display("FAIL %s dut%0d cnt got %h exp %h", name, m, act_cnt[m], e.cnt[m]);
      end
      checks++;
      if (act_tc[m] !== e.tc[m]) begin
        errors++;
        $display("FAIL %s dut%0d tc got %b exp %b", name, m, act_tc[m], e.tc[m]);
      end
      checks++;
      if (act_ovf[m] !== e.ovf[m]) begin
        errors++;
        $display("FAIL %s dut%0d ovf got %b exp %b", name, m, act_ovf[m], e.ovf[m]);
      end
      checks++;
      if (act_n[m] !== e.cnt_n[m]) begin
        errors++;
        $display("FAIL %s dut%0d cnt_n got %h exp %h", name, m, act_n[m], e.cnt_n[m]);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (cnt_w !== '0 || cnt_s !== '0) begin
      errors++;
      $display("FAIL %s cnt got %h/%h exp 0", name, cnt_w, cnt_s);
    end
    checks++;
    if (tc_w !== '0 || tc_s !== '0) begin
      errors++;
      $display("FAIL %s tc got %b/%b exp 0", name, tc_w, tc_s);
    end
    checks++;
    if (ovf_w !== '0 || ovf_s !== '0) begin
      errors++;
      $display("FAIL %s ovf got %b/%b exp 0", name, ovf_w, ovf_s);
    end
    checks++;
    if (cnt_n_w !== '0 || cnt_n_s !== '0) begin
      errors++;
      $display("FAIL %s cnt_n got %h/%h exp 0", name, cnt_n_w, cnt_n_s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_load();
    wen = 4'b0001;
    dat[7:0] = 8'hA5;
    step("load", 1'b0);
    checks++;
    if (cnt_w !== 32'h0000_00A5 || tc_w !== 4'b0000) begin
      errors++;
      $display("FAIL load_direct cnt/tc got %h/%b exp 000000a5/0000", cnt_w, tc_w);
    end
    idle_inputs();
  endtask

  task automatic test_wrap_up();
    wen[1] = 1'b1;
    dat[15:8] = 8'hFF;
    step("wrap_load", 1'b0);
    idle_inputs();
    cen[1] = 1'b1; dir[1] = 1'b1;
    step("wrap_step", 1'b0);
    checks++;
    if (cnt_w[15:8] !== 8'h00 || tc_w[1] !== 1'b1 || ovf_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_direct cnt/tc/ovf got %h/%b/%b exp 00/1/1", cnt_w[15:8], tc_w[1], ovf_w[1]);
    end
    idle_inputs();
    step("wrap_idle", 1'b0);
    checks++;
    if (tc_w[1] !== 1'b0 || ovf_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_after tc/ovf got %b/%b exp 0/1", tc_w[1], ovf_w[1]);
    end
  endtask

  task automatic test_sat_down();
    cen[2] = 1'b1; dir[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("sat_down", 1'b0);
      checks++;
      if (cnt_s[23:16] !== 8'h00 || tc_s[2] !== 1'b1) begin
        errors++;
        $display("FAIL sat_direct attempt %0d cnt/tc got %h/%b exp 00/1", k, cnt_s[23:16], tc_s[2]);
      end
    end
    idle_inputs();
    step("sat_idle", 1'b0);
    checks++;
    if (tc_s[2] !== 1'b0 || ovf_s[2] !== 1'b1) begin
      errors++;
      $display("FAIL sat_after tc/ovf got %b/%b exp 0/1", tc_s[2], ovf_s[2]);
    end
  endtask

  task automatic test_ovf_clear();
    wen[1] = 1'b1;
    dat[15:8] = 8'hFF;
    step("clr_load", 1'b0);
    idle_inputs();
    cen[1] = 1'b1; dir[1] = 1'b1; clr_ovf[1] = 1'b1;
    step("clr_with_set", 1'b0);
    checks++;
    if (ovf_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL clr_set_wins ovf got %b exp 1", ovf_w[1]);
    end
    idle_inputs();
    clr_ovf[1] = 1'b1;
    step("clr_alone", 1'b0);
    checks++;
    if (ovf_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone ovf got %b exp 0", ovf_w[1]);
    end
    idle_inputs();
  endtask

  task automatic test_load_priority();
    wen = 4'b1111; cen = 4'b1111; dir = 4'($urandom_range(0, 15));
    dat = {4{8'h10}};
    step("load_priority", 1'b0);
    checks++;
    if (cnt_w !== 32'h1010_1010 || tc_w !== 4'b0000 || tc_s !== 4'b0000) begin
      errors++;
      $display("FAIL load_priority_direct cnt/tc got %h/%b/%b exp 10101010/0000/0000", cnt_w, tc_w, tc_s);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < CH; i++) begin
        wen[i]     = ($urandom_range(0, 5) == 0);
        cen[i]     = 1'($urandom_range(0, 1));
        dir[i]     = 1'($urandom_range(0, 1));
        clr_ovf[i] = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 3))
          0:       dat[i*W +: W] = 8'hFF;
          1:       dat[i*W +: W] = 8'h00;
          2:       dat[i*W +: W] = 8'h01;
          default: dat[i*W +: W] = 8'($urandom_range(0, 255));
        endcase
      end
      step("back_to_back", 1'b0);
    end
    idle_inputs();
  endtask

  task automatic test_negedge_async();
    wen = 4'b1111; dat = '0;
    step("ne_load0", 1'b0);
    idle_inputs();
    cen = 4'b1111; dir = 4'b1111;
    repeat (4) step("ne_count", 1'b0);
    step("ne_count5", 1'b1);
    checks++;
`ifdef COUNTER_BANK_NEGEDGE_EN
    if (cnt_w[7:0] !== 8'd5 || cnt_n_w[7:0] !== 8'd5) begin
      errors++;
      $display("FAIL ne_direct cnt/cnt_n got %0d/%0d exp 5/5", cnt_w[7:0], cnt_n_w[7:0]);
    end
`else
    if (cnt_w[7:0] !== 8'd5 || cnt_n_w[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL ne_direct cnt/cnt_n got %0d/%0d exp 5/0", cnt_w[7:0], cnt_n_w[7:0]);
    end
`endif
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_clear();
    @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    step("post_reset", 1'b0);
    checks++;
    if (cnt_w[7:0] !== 8'd1) begin
      errors++;
      $display("FAIL post_reset_direct cnt got %0d exp 1", cnt_w[7:0]);
    end
    idle_inputs();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load();
    test_wrap_up();
    test_sat_down();
    test_ovf_clear();
    test_load_priority();
    test_back_to_back();
    test_negedge_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_counter_bank

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: bit width of each channel counter (>=2).
- REQ-002 SHALL have parameter CHANNELS, default 4: number of independent counter channels (>=1).
- REQ-003 SHALL have parameter SATURATE, default 0: 0 means wrap at bounds, 1 means saturate at bounds; applies to all channels.
- REQ-004 SHALL have port clk, input, 1 bit: single clock.
- REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 SHALL have port cen, input, CHANNELS bits: per-channel count enable.
- REQ-007 SHALL have port dir, input, CHANNELS bits: per-channel direction, 1 = up, 0 = down.
- REQ-008 SHALL have port wen, input, CHANNELS bits: per-channel synchronous load enable.
- REQ-009 SHALL have port dat, input, CHANNELS*WIDTH bits: load data, channel i at [i*WIDTH +: WIDTH].
- REQ-010 SHALL have port clr_ovf, input, CHANNELS bits: per-channel sticky overflow clear.
- REQ-011 SHALL have port cnt, output, CHANNELS*WIDTH bits: rising-edge count value, packed as dat.
- REQ-012 SHALL have port tc, output, CHANNELS bits: registered terminal-count pulse.
- REQ-013 SHALL have port ovf, output, CHANNELS bits: sticky overflow/underflow flag.
- REQ-014 SHALL have port cnt_n, output, CHANNELS*WIDTH bits: falling-edge count value (see Configuration).

Function
- REQ-015 Each channel SHALL update on the rising edge of clk, independently of the other channels.
- REQ-016 Update priority SHALL be: wen loads dat; else cen steps the counter by +1 when dir=1 or -1 when dir=0; else the counter holds.
- REQ-017 A load SHALL never assert tc, and a load of any value, including all-ones, SHALL be exact.
- REQ-018 With SATURATE=0, an up-step from 2^WIDTH-1 SHALL wrap to 0 and a down-step from 0 SHALL wrap to 2^WIDTH-1.
- REQ-019 With SATURATE=1, an up-step at 2^WIDTH-1 and a down-step at 0 SHALL leave the counter unchanged.
- REQ-020 tc SHALL be high for exactly the cycle after each step that crosses a bound (wrap or saturation attempt); repeated attempts SHALL give one tc cycle per attempt.
- REQ-021 ovf SHALL set on the same edge tc rises and hold until clr_ovf; if set and clear coincide, set SHALL win.
- REQ-022 Latency from a qualifying edge to the updated cnt, tc or ovf SHALL be one clock edge, with no combinational input-to-output path.

Reset
- REQ-023 rst_n low SHALL asynchronously force cnt, cnt_n, tc and ovf to all-zero.
- REQ-024 Reset SHALL take priority over wen and cen, and a mid-operation reset SHALL discard all in-progress state.
- REQ-025 Reset release SHALL be synchronous to clk by the integrator; the first update SHALL occur on the first edge after rst_n rises.

Configuration
- REQ-026 Macro COUNTER_BANK_NEGEDGE_EN defined: cnt_n SHALL be an independent per-channel counter clocked on the falling edge of clk, with the same load, step and bound rules as cnt, and without tc or ovf.
- REQ-027 Macro COUNTER_BANK_NEGEDGE_EN undefined: cnt_n SHALL be constant zero, no falling-edge flops SHALL exist, and the port list SHALL stay unchanged.

Structure
- REQ-028 Package counter_bank_pkg SHALL hold the direction constants (DIR_UP=1, DIR_DOWN=0) and the mode constants (MODE_WRAP=0, MODE_SAT=1).
- REQ-029 Sub-module counter_bank_ch SHALL implement one channel (count logic, tc, ovf, optional negedge copy), and counter_bank SHALL instantiate it CHANNELS times in a generate loop.

Verification
- REQ-030 Apply reset, then wen[0]=1 with dat ch0=0xA5 -> cnt ch0=0xA5, tc=0; the other channels stay 0.
- REQ-031 SATURATE=0, ch1 loaded 0xFF, cen=1, dir=1 for one cycle -> cnt ch1=0x00, tc[1] high one cycle, ovf[1]=1.
- REQ-032 SATURATE=1, ch2 at 0x00, dir=0, cen=1 for 3 cycles -> cnt ch2 stays 0x00, tc[2] high for 3 cycles, ovf[2]=1.
- REQ-033 ovf[1]=1, clr_ovf[1]=1 in the same cycle as a new wrap -> ovf[1] stays 1; next cycle clr_ovf[1]=1 alone -> ovf[1]=0.
- REQ-034 wen=1 and cen=1 together with dat=0x10 -> cnt=0x10 (load wins), tc=0.
- REQ-035 With COUNTER_BANK_NEGEDGE_EN, count 5 rising edges with cen=1 -> cnt and cnt_n both 5, with cnt_n changing half a cycle later; assert rst_n low mid-count -> all outputs 0 immediately.
